// File: rtl/pcie_us_msi_pkg.sv
// Shared definitions for the multi-function MSI request generator.
//
// Contents:
//   msi_state_e        - request sequencer states
//   *_TIE              - constant values for the MSI outputs this block never drives
//   granted_vectors()  - vector window allowed by a 3-bit multiple-message-enable field
//   lowest_set()       - index of the least significant set bit of a 32-bit word
package pcie_us_msi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_BACKOFF = 2'd3
    } msi_state_e;

    localparam logic [31:0] PENDING_STATUS_TIE      = 32'h0;
    localparam logic        PENDING_DATA_ENABLE_TIE = 1'b0;
    localparam logic [3:0]  PENDING_FUNC_NUM_TIE    = 4'h0;
    localparam logic [2:0]  ATTR_TIE                = 3'h0;
    localparam logic        TPH_PRESENT_TIE         = 1'b0;
    localparam logic [1:0]  TPH_TYPE_TIE            = 2'h0;
    localparam logic [8:0]  TPH_ST_TAG_TIE          = 9'h0;

    // The host grants 2^mm vectors; encodings above 5 are treated as the
    // full 32-vector window.
    function automatic logic [31:0] granted_vectors(input logic [2:0] mm);
        logic [31:0] window;
        case (mm)
            3'd0:    window = 32'h0000_0001;
            3'd1:    window = 32'h0000_0003;
            3'd2:    window = 32'h0000_000F;
            3'd3:    window = 32'h0000_00FF;
            3'd4:    window = 32'h0000_FFFF;
            default: window = 32'hFFFF_FFFF;
        endcase
        return window;
    endfunction

    // Scanning from the top down lets the lowest set bit overwrite the rest.
    function automatic logic [4:0] lowest_set(input logic [31:0] bits);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (bits[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pcie_us_msi_mf_arbiter_rr.sv
// Round-robin arbiter over the physical functions.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   req[N-1:0]   - function has at least one eligible vector
//   advance      - the current grant is being taken; move priority past it
//   grant_valid  - some request is present
//   grant_idx    - granted function (priority encoded from the pointer)
module arbiter_rr #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic         grant_valid,
    output logic [1:0]   grant_idx
);

    // ptr_q names the function with highest priority, i.e. the one after
    // the last function that was granted.
    logic [1:0] ptr_q;
    int         best_dist;

    function automatic int rr_distance(input int j, input int p);
        return (j >= p) ? (j - p) : (j - p + N);
    endfunction

    // Pick the requester closest to the pointer, walking upward with wrap.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        best_dist   = N;
        for (int j = 0; j < N; j++) begin
            if (req[j] && (rr_distance(j, int'(ptr_q)) < best_dist)) begin
                best_dist   = rr_distance(j, int'(ptr_q));
                grant_valid = 1'b1;
                grant_idx   = 2'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else if (advance && grant_valid) begin
            ptr_q <= (int'(grant_idx) == N - 1) ? 2'd0 : grant_idx + 2'd1;
        end
    end

endmodule

// File: rtl/pcie_us_msi_mf.sv
// Multi-function MSI request generator for the UltraScale PCIe hard core.
// Collects single-cycle vector requests into per-function pending words,
// applies enable / multiple-message / mask qualification, and hands one
// vector at a time to the core, retrying after a back-off when it fails.
//
// Ports:
//   clk, rst                           - clock, synchronous active-high reset
//   msi_irq                            - request pulses, bit f*MSI_COUNT+v
//   cfg_interrupt_msi_enable/mmenable  - per-function enable and log2 vector grant
//   cfg_interrupt_msi_mask_update/data - mask word for the function on select
//   cfg_interrupt_msi_select           - function whose mask is being sampled
//   cfg_interrupt_msi_int              - one-hot vector pulse to the core
//   cfg_interrupt_msi_function_number  - function of that pulse
//   cfg_interrupt_msi_sent/fail        - completion status from the core
//   remaining cfg_interrupt_msi_*      - constant zero
module pcie_us_msi_mf
    import pcie_us_msi_pkg::*;
#(
    parameter int FUNC_COUNT  = 1,
    parameter int MSI_COUNT   = 32,
    parameter int RETRY_DELAY = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FUNC_COUNT*MSI_COUNT-1:0] msi_irq,
    input  logic [3:0]                      cfg_interrupt_msi_enable,
    input  logic [11:0]                     cfg_interrupt_msi_mmenable,
    input  logic                            cfg_interrupt_msi_mask_update,
    input  logic [31:0]                     cfg_interrupt_msi_data,
    output logic [3:0]                      cfg_interrupt_msi_select,
    output logic [31:0]                     cfg_interrupt_msi_int,
    output logic [3:0]                      cfg_interrupt_msi_function_number,
    input  logic                            cfg_interrupt_msi_sent,
    input  logic                            cfg_interrupt_msi_fail,
    output logic [31:0]                     cfg_interrupt_msi_pending_status,
    output logic                            cfg_interrupt_msi_pending_status_data_enable,
    output logic [3:0]                      cfg_interrupt_msi_pending_status_function_num,
    output logic [2:0]                      cfg_interrupt_msi_attr,
    output logic                            cfg_interrupt_msi_tph_present,
    output logic [1:0]                      cfg_interrupt_msi_tph_type,
    output logic [8:0]                      cfg_interrupt_msi_tph_st_tag
);

    localparam int CNT_W = $clog2(RETRY_DELAY + 1);
    localparam logic [31:0] COUNT_MASK =
        (MSI_COUNT >= 32) ? 32'hFFFF_FFFF : ((32'd1 << MSI_COUNT) - 32'd1);

    msi_state_e       state_q, state_d;
    logic [31:0]      pending_q [FUNC_COUNT];
    logic [31:0]      mask_q    [FUNC_COUNT];
    logic [31:0]      irq_vec   [FUNC_COUNT];
    logic [31:0]      elig_vec  [FUNC_COUNT];
    logic [31:0]      clear_vec [FUNC_COUNT];
    logic [FUNC_COUNT-1:0] func_req;
    logic [1:0]       select_q, select_d;
    logic [1:0]       fn_q, fn_d;
    logic [4:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arb_advance;
    logic             arb_valid;
    logic [1:0]       arb_idx;
    logic [31:0]      chosen_vec;
    logic             clear_en;
    logic             unused_cfg;

    // Enable and mmenable carry fields for all four possible functions.
    assign unused_cfg = ^{cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable};

    // Per-function request words, eligibility and the vector cleared on sent.
    always_comb begin
        for (int f = 0; f < FUNC_COUNT; f++) begin
            irq_vec[f]  = 32'(msi_irq[f*MSI_COUNT +: MSI_COUNT]);
            elig_vec[f] = cfg_interrupt_msi_enable[f]
                        ? (pending_q[f] & ~mask_q[f] & COUNT_MASK &
                           granted_vectors(cfg_interrupt_msi_mmenable[3*f +: 3]))
                        : 32'h0;
            func_req[f] = |elig_vec[f];
            clear_vec[f] = (clear_en && (int'(fn_q) == f)) ? (32'd1 << vec_q) : 32'h0;
        end
    end

    // The arbiter pointer moves past each granted function, so a function
    // that just failed gives way to any other eligible function on retry.
    arbiter_rr #(
        .N (FUNC_COUNT)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (func_req),
        .advance     (arb_advance),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    always_comb begin
        chosen_vec = 32'h0;
        for (int f = 0; f < FUNC_COUNT; f++) begin
            if (int'(arb_idx) == f) begin
                chosen_vec = elig_vec[f];
            end
        end
    end

    // Next-state logic; the served function/vector are latched on entry to
    // SEND and stay stable until the core reports the outcome.
    always_comb begin
        state_d     = state_q;
        fn_d        = fn_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        arb_advance = 1'b0;
        clear_en    = 1'b0;
        select_d    = select_q;
        case (state_q)
            ST_IDLE: begin
                select_d = (int'(select_q) == FUNC_COUNT - 1) ? 2'd0 : select_q + 2'd1;
                if (arb_valid) begin
                    state_d     = ST_SEND;
                    fn_d        = arb_idx;
                    vec_d       = lowest_set(chosen_vec);
                    arb_advance = 1'b1;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cfg_interrupt_msi_sent) begin
                    clear_en = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cfg_interrupt_msi_fail) begin
                    cnt_d   = CNT_W'(RETRY_DELAY);
                    state_d = ST_BACKOFF;
                end
            end
            ST_BACKOFF: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers. A request arriving in the same cycle as the clear
    // of its own bit wins, so that pulse is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            select_q <= 2'd0;
            fn_q     <= 2'd0;
            vec_q    <= 5'd0;
            cnt_q    <= '0;
            for (int f = 0; f < FUNC_COUNT; f++) begin
                pending_q[f] <= 32'h0;
                mask_q[f]    <= 32'h0;
            end
        end else begin
            select_q <= select_d;
            fn_q     <= fn_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            for (int f = 0; f < FUNC_COUNT; f++) begin
                pending_q[f] <= (pending_q[f] & ~clear_vec[f]) | irq_vec[f];
                if (cfg_interrupt_msi_mask_update && (int'(select_q) == f)) begin
                    mask_q[f] <= cfg_interrupt_msi_data;
                end
            end
        end
    end

    assign cfg_interrupt_msi_select          = {2'b00, select_q};
    assign cfg_interrupt_msi_int             = (state_q == ST_SEND) ? (32'd1 << vec_q) : 32'h0;
    assign cfg_interrupt_msi_function_number = (state_q == ST_SEND) ? {2'b00, fn_q} : 4'h0;

    assign cfg_interrupt_msi_pending_status              = PENDING_STATUS_TIE;
    assign cfg_interrupt_msi_pending_status_data_enable  = PENDING_DATA_ENABLE_TIE;
    assign cfg_interrupt_msi_pending_status_function_num = PENDING_FUNC_NUM_TIE;
    assign cfg_interrupt_msi_attr                        = ATTR_TIE;
    assign cfg_interrupt_msi_tph_present                 = TPH_PRESENT_TIE;
    assign cfg_interrupt_msi_tph_type                    = TPH_TYPE_TIE;
    assign cfg_interrupt_msi_tph_st_tag                  = TPH_ST_TAG_TIE;

endmodule

// File: tb/tb_pcie_us_msi_mf.sv
// Self-checking bench for pcie_us_msi_mf with two functions of 32 vectors.
module tb_pcie_us_msi_mf;

    localparam int FC = 2;
    localparam int MC = 32;
    localparam int RD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   msi_irq;
    logic [3:0]    cfg_en;
    logic [11:0]   cfg_mm;
    logic          cfg_mask_update;
    logic [31:0]   cfg_data;
    logic [3:0]    cfg_select;
    logic [31:0]   cfg_int;
    logic [3:0]    cfg_fn;
    logic          cfg_sent;
    logic          cfg_fail;
    logic [31:0]   ps;
    logic          ps_de;
    logic [3:0]    ps_fn;
    logic [2:0]    attr;
    logic          tph_p;
    logic [1:0]    tph_t;
    logic [8:0]    tph_tag;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pcie_us_msi_mf #(
        .FUNC_COUNT  (FC),
        .MSI_COUNT   (MC),
        .RETRY_DELAY (RD)
    ) dut (
        .clk                                          (clk),
        .rst                                          (rst),
        .msi_irq                                      (msi_irq),
        .cfg_interrupt_msi_enable                     (cfg_en),
        .cfg_interrupt_msi_mmenable                   (cfg_mm),
        .cfg_interrupt_msi_mask_update                (cfg_mask_update),
        .cfg_interrupt_msi_data                       (cfg_data),
        .cfg_interrupt_msi_select                     (cfg_select),
        .cfg_interrupt_msi_int                        (cfg_int),
        .cfg_interrupt_msi_function_number            (cfg_fn),
        .cfg_interrupt_msi_sent                       (cfg_sent),
        .cfg_interrupt_msi_fail                       (cfg_fail),
        .cfg_interrupt_msi_pending_status             (ps),
        .cfg_interrupt_msi_pending_status_data_enable (ps_de),
        .cfg_interrupt_msi_pending_status_function_num(ps_fn),
        .cfg_interrupt_msi_attr                       (attr),
        .cfg_interrupt_msi_tph_present                (tph_p),
        .cfg_interrupt_msi_tph_type                   (tph_t),
        .cfg_interrupt_msi_tph_st_tag                 (tph_tag)
    );

    typedef struct {
        string       name;
        logic [63:0] irq;
        logic [3:0]  en;
        logic [11:0] mm;
        logic [31:0] exp_int;
        logic [3:0]  exp_fn;
    } vec_t;

    vec_t tbl [11];

    // Behavioural model of the pending words and the round-robin pointer.
    bit [31:0] mpend [2];
    bit [31:0] mprev [2];
    int        mptr;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock: inputs held across the rising edge, outputs sampled after
    // the falling edge; pulse inputs drop back to zero afterwards.
    task automatic applyStimulus(input logic [63:0] irq, input logic sent, input logic fail);
        msi_irq  = irq;
        cfg_sent = sent;
        cfg_fail = fail;
        @(posedge clk);
        @(negedge clk);
        msi_irq  = '0;
        cfg_sent = 1'b0;
        cfg_fail = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic expectQuiet(input string name, input int n);
        logic [31:0] seen;
        seen = cfg_int;
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, 1'b0, 1'b0);
            seen |= cfg_int;
        end
        checkOutput(name, seen, 32'h0);
    endtask

    task automatic waitInt(input int limit, output int steps, output logic [31:0] val);
        steps = 0;
        while (cfg_int == 32'h0 && steps < limit) begin
            applyStimulus('0, 1'b0, 1'b0);
            steps++;
        end
        val = cfg_int;
    endtask

    // Vectors granted by the host for function f under the current mmenable.
    function automatic bit [31:0] eligMask(input int f);
        int mmv;
        mmv = int'(cfg_mm[3*f +: 3]);
        if (mmv >= 5) return 32'hFFFF_FFFF;
        return (32'd1 << (1 << mmv)) - 32'd1;
    endfunction

    function automatic int lowestBit(input bit [31:0] w);
        for (int i = 0; i < 32; i++) begin
            if (w[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          steps;
        logic [31:0] val;
        int          ef, ev, inf_f, inf_v;
        bit          wait_resp, s, fl;
        logic [63:0] irq;
        bit [31:0]   left;

        rst = 1'b1; msi_irq = '0; cfg_en = 4'h0; cfg_mm = 12'h0;
        cfg_mask_update = 1'b0; cfg_data = 32'h0; cfg_sent = 1'b0; cfg_fail = 1'b0;

        tbl[0]  = '{"f0_v3_mm5",    64'h0000_0000_0000_0008, 4'h1, 12'o05, 32'h0000_0008, 4'd0};
        tbl[1]  = '{"f1_v0",        64'h0000_0001_0000_0000, 4'h3, 12'o55, 32'h0000_0001, 4'd1};
        tbl[2]  = '{"f0_v31",       64'h0000_0000_8000_0000, 4'h1, 12'o05, 32'h8000_0000, 4'd0};
        tbl[3]  = '{"f0_v31_mm7",   64'h0000_0000_8000_0000, 4'h1, 12'o07, 32'h8000_0000, 4'd0};
        tbl[4]  = '{"f0_v4_mm2",    64'h0000_0000_0000_0010, 4'h1, 12'o02, 32'h0000_0000, 4'd0};
        tbl[5]  = '{"f0_v3_mm2",    64'h0000_0000_0000_0008, 4'h1, 12'o02, 32'h0000_0008, 4'd0};
        tbl[6]  = '{"f0_v1_mm0",    64'h0000_0000_0000_0002, 4'h1, 12'o00, 32'h0000_0000, 4'd0};
        tbl[7]  = '{"f0_disabled",  64'h0000_0000_0000_0020, 4'h2, 12'o55, 32'h0000_0000, 4'd0};
        tbl[8]  = '{"f1_v16_mm4",   64'h0001_0000_0000_0000, 4'h3, 12'o45, 32'h0000_0000, 4'd0};
        tbl[9]  = '{"f1_v15_mm4",   64'h0000_8000_0000_0000, 4'h3, 12'o45, 32'h0000_8000, 4'd1};
        tbl[10] = '{"f0_v0_mm0",    64'h0000_0000_0000_0001, 4'h1, 12'o00, 32'h0000_0001, 4'd0};

        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("reset_int", cfg_int, 32'h0);
        checkOutput("reset_fn", cfg_fn, 4'h0);
        checkOutput("reset_select", cfg_select, 4'h0);
        checkOutput("tieoffs", {ps, ps_de, ps_fn, attr, tph_p, tph_t, tph_tag}, 64'h0);
        rst = 1'b0;
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("select_step1", cfg_select, 4'h1);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("select_wrap", cfg_select, 4'h0);

        // Single-request table: latency, vector window, enable.
        for (int i = 0; i < 11; i++) begin
            doReset();
            cfg_en = tbl[i].en;
            cfg_mm = tbl[i].mm;
            applyStimulus(tbl[i].irq, 1'b0, 1'b0);
            checkOutput({tbl[i].name, "_early"}, cfg_int, 32'h0);
            applyStimulus('0, 1'b0, 1'b0);
            checkOutput({tbl[i].name, "_int"}, cfg_int, tbl[i].exp_int);
            checkOutput({tbl[i].name, "_fn"}, cfg_fn, tbl[i].exp_fn);
            if (tbl[i].exp_int != 32'h0) begin
                applyStimulus('0, 1'b0, 1'b0);
                applyStimulus('0, 1'b1, 1'b0);
                expectQuiet({tbl[i].name, "_cleared"}, 6);
            end else begin
                expectQuiet({tbl[i].name, "_held"}, 6);
            end
        end

        // Two vectors at once: lowest first, the other after its sent.
        doReset();
        cfg_en = 4'h1; cfg_mm = 12'o05;
        applyStimulus(64'h24, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("pair_first", cfg_int, 32'h4);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("pair_second", cfg_int, 32'h20);

        // Masking holds the request until the mask is lifted.
        doReset();
        cfg_en = 4'h1; cfg_mm = 12'o05;
        cfg_mask_update = 1'b1; cfg_data = 32'h4;
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        cfg_mask_update = 1'b0;
        applyStimulus(64'h4, 1'b0, 1'b0);
        expectQuiet("masked_held", 8);
        cfg_mask_update = 1'b1; cfg_data = 32'h0;
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        cfg_mask_update = 1'b0;
        waitInt(8, steps, val);
        checkOutput("unmasked_int", val, 32'h4);

        // Fail: back-off window plus one arbitration cycle, then resend.
        doReset();
        cfg_en = 4'h1; cfg_mm = 12'o05;
        applyStimulus(64'h8, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("retry_first", cfg_int, 32'h8);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b1);
        waitInt(40, steps, val);
        checkOutput("retry_gap", steps, RD + 1);
        checkOutput("retry_int", val, 32'h8);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b1);
        expectQuiet("sent_wins", RD + 4);

        // Two functions alternate under round-robin.
        doReset();
        cfg_en = 4'h3; cfg_mm = 12'o55;
        for (int r = 0; r < 2; r++) begin
            applyStimulus(64'h0000_0001_0000_0001, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                applyStimulus('0, 1'b0, 1'b0);
                checkOutput($sformatf("rr_fn_%0d_%0d", r, k), cfg_fn, 4'(k));
                checkOutput($sformatf("rr_int_%0d_%0d", r, k), cfg_int, 32'h1);
                applyStimulus('0, 1'b0, 1'b0);
                applyStimulus('0, 1'b1, 1'b0);
            end
        end

        // Vector outside the granted window waits for a larger grant.
        doReset();
        cfg_en = 4'h3; cfg_mm = 12'o05;
        applyStimulus(64'h0000_0002_0000_0000, 1'b0, 1'b0);
        expectQuiet("mm0_held", 6);
        cfg_mm = 12'o15;
        waitInt(8, steps, val);
        checkOutput("mm1_int", val, 32'h2);
        checkOutput("mm1_fn", cfg_fn, 4'h1);

        // Reset while waiting on the core drops the request.
        doReset();
        cfg_en = 4'h1; cfg_mm = 12'o05;
        applyStimulus(64'h8, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("rstwait_int", cfg_int, 32'h8);
        applyStimulus('0, 1'b0, 1'b0);
        doReset();
        checkOutput("rstwait_select", cfg_select, 4'h0);
        expectQuiet("rstwait_quiet", RD + 6);

        // Randomised traffic against the pending/round-robin model.
        doReset();
        cfg_en = 4'h3;
        cfg_mm = {6'd0, 3'($urandom_range(7)), 3'($urandom_range(7))};
        mpend[0] = '0; mpend[1] = '0; mptr = 0;
        wait_resp = 1'b0; inf_f = 0; inf_v = 0;
        for (int c = 0; c < 3600; c++) begin
            s = 1'b0; fl = 1'b0;
            if (wait_resp) begin
                fl = ($urandom_range(3) == 0);
                s  = !fl;
                wait_resp = 1'b0;
            end
            if (cfg_int != 32'h0) begin
                ef = -1;
                for (int k = 0; k < 2; k++) begin
                    if (ef < 0 && (mprev[(mptr + k) % 2] & eligMask((mptr + k) % 2)) != 0)
                        ef = (mptr + k) % 2;
                end
                if (ef >= 0) begin
                    ev = lowestBit(mprev[ef] & eligMask(ef));
                    checkOutput("rand_int", cfg_int, 32'd1 << ev);
                    checkOutput("rand_fn", cfg_fn, 4'(ef));
                    inf_f = ef; inf_v = ev;
                    mptr = (ef + 1) % 2;
                end else begin
                    checkOutput("rand_spurious", cfg_int, 32'h0);
                end
                wait_resp = 1'b1;
            end
            irq = '0;
            if (c < 600 && $urandom_range(2) == 0) irq = 64'd1 << $urandom_range(63);
            if (c >= 600) begin
                left = (mpend[0] & eligMask(0)) | (mpend[1] & eligMask(1));
                if (left == 0 && !wait_resp && !s && !fl && cfg_int == 32'h0) break;
            end
            mprev = mpend;
            if (s) mpend[inf_f][inf_v] = 1'b0;
            mpend[0] |= irq[31:0];
            mpend[1] |= irq[63:32];
            applyStimulus(irq, s, fl);
        end
        left = (mpend[0] & eligMask(0)) | (mpend[1] & eligMask(1));
        checkOutput("rand_drained", left, 32'h0);
        expectQuiet("rand_idle", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
